// File: rtl/move_arb_pkg.sv
// Shared types and requester index names for the move arbiter.
package move_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  localparam int REQ_LEFT  = 0;
  localparam int REQ_RIGHT = 1;
  localparam int REQ_ROT   = 2;
  localparam int REQ_GRAV  = 3;

endpackage

// File: rtl/move_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set pend bit after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  always_comb begin : pick
    logic [IDX_W-1:0] j;
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = '0;
    // N_REQ is a power of two, so index wrap is plain truncation.
    for (int k = 1; k <= N_REQ; k++) begin
      j = ptr + IDX_W'(k);
      if (!any && pend[j]) begin
        any     = 1'b1;
        win_idx = j;
      end
    end
    win[win_idx] = any;
  end

endmodule

// File: rtl/move_arbiter.sv
// Round-robin arbiter sharing the board-update engine between game-event requesters.
module move_arbiter
  import move_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = $clog2(N_REQ),
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             eng_ready,
  input  logic             eng_done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             busy,
  output logic [N_REQ-1:0] pend,
  output logic             timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [WD_W-1:0]  wd;

  logic [N_REQ-1:0] win;
  logic [IDX_W-1:0] win_idx;
  logic             any;
  logic             accept;
  logic [N_REQ-1:0] clr;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .pend    (pend),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  assign accept = grant_valid && eng_ready && (state == OFFER);
  assign clr    = accept ? grant : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      busy        <= 1'b0;
      pend        <= '0;
      timeout_err <= 1'b0;
      ptr         <= IDX_W'(N_REQ-1);
      wd          <= '0;
    end else begin
      timeout_err <= 1'b0;
      // A new pulse on the accept cycle survives the clear.
      pend <= (pend & ~clr) | req;
      case (state)
        IDLE: if (any) begin
          grant       <= win;
          grant_idx   <= win_idx;
          grant_valid <= 1'b1;
          state       <= OFFER;
        end
        OFFER: if (accept) begin
          ptr         <= grant_idx;
          busy        <= 1'b1;
          grant_valid <= 1'b0;
          wd          <= '0;
          state       <= BUSY;
        end
        BUSY: begin
          // Watchdog abort drops the command; its pend bit is not restored.
          if (eng_done || wd == WD_W'(TIMEOUT-1)) begin
            grant       <= '0;
            grant_idx   <= '0;
            busy        <= 1'b0;
            wd          <= '0;
            timeout_err <= !eng_done;
            state       <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_arbiter.sv
// Scoreboarded directed bench for move_arbiter (N_REQ=4, TIMEOUT=16).
module tb_move_arbiter;
  import move_arb_pkg::*;

  localparam int N_REQ   = 4;
  localparam int IDX_W   = 2;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [N_REQ-1:0] g;
    logic [IDX_W-1:0] idx;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic             eng_ready = 1'b0;
  logic             eng_done = 1'b0;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             busy;
  logic [N_REQ-1:0] pend;
  logic             timeout_err;

  int   checks = 0;
  int   fails  = 0;
  exp_t exp_q[$];

  move_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .eng_ready   (eng_ready),
    .eng_done    (eng_done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .busy        (busy),
    .pend        (pend),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N_REQ-1:0] g, input logic [IDX_W-1:0] idx);
    exp_t e;
    e.g = g;
    e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic [N_REQ-1:0] v);
    req = v;
    tick();
    req = '0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {grant, grant_idx, grant_valid, busy, pend, timeout_err}, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    eng_done = 1'b0;
    repeat (2) tick();
    chk_all_zero("reset_outputs");
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 40) begin
      tick();
      n++;
    end
    chk("busy_wait", {31'd0, busy}, 1);
  endtask

  task automatic wait_gv();
    int n = 0;
    while (!grant_valid && n < 40) begin
      tick();
      n++;
    end
    chk("gv_wait", {31'd0, grant_valid}, 1);
  endtask

  // Assert done d cycles after the accept, then confirm the grant is released.
  task automatic serve(input int d);
    wait_busy();
    repeat (d-1) tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("done_busy", {31'd0, busy}, 0);
    chk("done_grant", {28'd0, grant}, 0);
  endtask

  // Monitor: each new offer is compared against the oldest expected grant.
  initial begin : monitor
    logic prev_gv;
    exp_t e;
    prev_gv = 1'b0;
    forever begin
      @(negedge clk);
      if (grant_valid && !prev_gv) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL offer_unexpected: got grant %b, expected no offer", grant);
        end else begin
          e = exp_q.pop_front();
          chk("offer_grant", {28'd0, grant}, {28'd0, e.g});
          chk("offer_idx", {30'd0, grant_idx}, {30'd0, e.idx});
        end
      end
      prev_gv = grant_valid;
    end
  end

  initial begin : stim
    int hit;

    // Single request, latency and release.
    eng_ready = 1'b1;
    do_reset();
    push(4'b0100, 2);
    pulse(4'b0100);
    chk("lat_pend", {28'd0, pend}, 32'h4);
    chk("lat_gv_early", {31'd0, grant_valid}, 0);
    tick();
    chk("lat_gv", {31'd0, grant_valid}, 1);
    tick();
    chk("lat_gv_one_cycle", {31'd0, grant_valid}, 0);
    chk("lat_busy", {31'd0, busy}, 1);
    repeat (2) tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("single_release", {28'd0, grant, busy}, 0);

    // Fairness from reset pointer.
    do_reset();
    push(4'b0001, 0); push(4'b0010, 1); push(4'b0100, 2); push(4'b1000, 3);
    pulse(4'b1111);
    repeat (4) serve(2);
    repeat (2) tick();
    chk("fair_idle", {28'd0, pend, grant_valid, busy}, 0);

    // Rotation: ptr=1, so 0 is picked before 1.
    do_reset();
    push(4'b0010, 1);
    pulse(4'b0010);
    serve(2);
    push(4'b0001, 0); push(4'b0010, 1);
    pulse(4'b0011);
    serve(2);
    serve(2);

    // Backpressure: offer stays frozen while a higher-priority request arrives.
    eng_ready = 1'b0;
    push(4'b0100, 2);
    pulse(4'b0100);
    wait_gv();
    for (int i = 0; i < 5; i++) begin
      req = (i == 1) ? 4'b0001 : 4'b0000;
      tick();
      chk("bp_hold", {26'd0, grant, grant_idx, grant_valid}, {26'd0, 4'b0100, 2'd2, 1'b1});
    end
    req = '0;
    eng_ready = 1'b1;
    tick();
    chk("bp_accept", {27'd0, grant, busy}, {27'd0, 4'b0100, 1'b1});
    push(4'b0001, 0);
    serve(2);
    serve(2);

    // Re-request on its own accept cycle is serviced again.
    do_reset();
    eng_ready = 1'b0;
    push(4'b1000, 3); push(4'b1000, 3);
    pulse(4'b1000);
    wait_gv();
    eng_ready = 1'b1;
    req = 4'b1000;
    tick();
    req = '0;
    chk("rereq_pend", {28'd0, pend}, 32'h8);
    chk("rereq_busy", {31'd0, busy}, 1);
    serve(2);
    serve(2);
    tick();
    chk("rereq_pend_clear", {28'd0, pend}, 0);

    // Watchdog: no done, abort 16 cycles after entering BUSY.
    push(4'b0001, 0);
    pulse(4'b0001);
    wait_busy();
    hit = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (timeout_err) begin
        hit = k;
        break;
      end
    end
    chk("wd_cycles", hit, 16);
    chk("wd_release", {26'd0, grant, grant_idx, busy, grant_valid}, 0);
    tick();
    chk("wd_pulse_once", {31'd0, timeout_err}, 0);

    // Async reset mid-cycle while BUSY.
    push(4'b0010, 1);
    pulse(4'b0010);
    wait_busy();
    pulse(4'b1000);
    #3 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("async_stay_idle", {31'd0, grant_valid}, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL sim_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/move_arbiter.md
Name: move_arbiter

Overview:
- Round-robin arbiter that shares the single board-update engine between game-event requesters: left, right, rotate and gravity tick.
- Latches single-cycle request pulses, picks one winner, and drives a one-hot grant plus its binary index to the engine.
- Holds the grant until the engine signals done.
- Sits between the input debouncers / gravity timer and the board-update engine.

Parameters:
- N_REQ, 4, number of requesters; must be a power of two, minimum 2.
- IDX_W, $clog2(N_REQ), width of the binary grant index.
- TIMEOUT, 255, maximum cycles in BUSY before forced abort; minimum 2.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  request pulses, one per requester.
- eng_ready  input  1  engine can accept a command.
- eng_done  input  1  engine finished the current command (pulse).
- grant  output  N_REQ  one-hot grant; all-zero when no grant is active.
- grant_idx  output  IDX_W  binary index of the grant bit.
- grant_valid  output  1  command offered to the engine.
- busy  output  1  engine is executing a granted command.
- pend  output  N_REQ  latched pending requests, for debug/LED display.
- timeout_err  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, grant=0, grant_idx=0, grant_valid=0, busy=0, pend=0, timeout_err=0, last-winner pointer ptr=N_REQ-1 (so index 0 has top priority first), watchdog=0.
- Pending latch:
  - pend[i] is set on any cycle req[i]=1.
  - pend[i] is cleared on the accept cycle for i.
  - If set and clear hit the same cycle, set wins: pend[i] stays 1 and i is serviced again later.
- Rotating priority: winner = first set pend bit scanning ptr+1, ptr+2, … modulo N_REQ.
- States: IDLE, OFFER, BUSY.
  - IDLE: if |pend, register winner into grant/grant_idx and go to OFFER. Otherwise stay.
  - OFFER: grant_valid=1 and grant/grant_idx held stable.
    - Accept = grant_valid && eng_ready.
    - On accept: clear pend[winner], ptr<=winner, busy<=1, grant_valid<=0, go to BUSY.
    - No re-arbitration while in OFFER, even if higher-priority pend bits arrive.
  - BUSY: grant/grant_idx held. The watchdog counts up from 0.
    - eng_done=1: grant<=0, busy<=0, watchdog<=0, go to IDLE.
    - Watchdog reaches TIMEOUT-1 without done: timeout_err pulses 1 cycle and the state goes to IDLE with grant cleared. pend[winner] is not restored, so the command is dropped.
- eng_done outside BUSY is ignored. eng_ready outside OFFER is ignored.
- Latency:
  - req pulse at cycle t → pend at t+1 → grant_valid at t+2 if IDLE and this requester wins.
  - Back-to-back service: done at cycle d → next grant_valid at d+2 (one IDLE cycle).
- grant_idx always equals the binary encoding of grant while grant≠0, and 0 when grant=0.
- Reset mid-operation: all state returns to reset values immediately. Pending requests are lost.
- Outputs are registered. No combinational path exists from req/eng_ready/eng_done to any output.

Decomposition:
- Package move_arb_pkg:
  - state enum arb_state_t {IDLE, OFFER, BUSY}.
  - Named requester index constants REQ_LEFT=0, REQ_RIGHT=1, REQ_ROT=2, REQ_GRAV=3.
- Sub-module rr_pick (combinational):
  - Inputs: pend, ptr.
  - Outputs: one-hot winner, binary winner index, any.
  - Instantiated once. The FSM, pend latch and watchdog live in move_arbiter.

Test Plan (N_REQ=4, TIMEOUT=16):
- Reset sequence: after reset, single req[2] pulse, eng_ready=1 → grant=0100, grant_idx=2, grant_valid high 2 cycles after the pulse for one cycle. eng_done 3 cycles later → grant=0, busy=0.
- Fairness: req=1111 pulsed once, eng_ready=1, done 2 cycles after each accept → grants in order 0001, 0010, 0100, 1000, then pend=0 and IDLE.
- Rotation: after ptr=1, pulse req=0011 → grant 0001 (idx 0) before 0010.
- Backpressure: eng_ready=0 for 5 cycles in OFFER while req[0] pulses → grant, grant_idx and grant_valid held stable. Grant unchanged when eng_ready rises.
- Re-request during service: req[3] pulses on its own accept cycle → pend[3] stays 1 and requester 3 is granted a second time.
- Watchdog: grant accepted, no eng_done → timeout_err pulses exactly 16 cycles after entering BUSY, grant=0, state IDLE.
- Async reset asserted in BUSY mid-cycle → all outputs 0 and pend=0 before the next clock edge.
